// File: rtl/tt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tt_sweep_ctrl
// Brief    : Drives a 4-input combinational netlist through all 16 input
//            vectors, holds each vector for a programmable settle time,
//            captures the output into a truth-table word and compares it
//            against a latched expected truth table.
// Revision : 1.0 - initial release
// ============================================================================
module tt_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [15:0] i_expected_tt,
  input  logic        i_dut_out,
  output logic [3:0]  o_dut_in,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_tt_captured,
  output logic        o_match,
  output logic [4:0]  o_mismatch_count,
  output logic [3:0]  o_first_fail_idx
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [7:0] c_SETTLE = 8'(SETTLE_CYCLES);
  localparam logic [3:0] c_LAST_IDX = 4'd15;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [15:0] r_expected;
  logic [3:0]  r_idx;
  logic [7:0]  r_cnt;
  logic [15:0] r_tt;
  logic [4:0]  r_mm_cnt;
  logic [3:0]  r_first_fail;
  logic        r_match;

  logic        w_sample;
  logic        w_miss;
  logic [4:0]  w_mm_next;

  // The current vector is sampled once its settle counter has run out.
  assign w_sample  = (r_cnt == 8'd0);
  assign w_miss    = i_dut_out ^ r_expected[r_idx];
  assign w_mm_next = r_mm_cnt + {4'd0, w_miss};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; abort wins over the final sample of a sweep.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (i_start) begin
          w_next_state = c_RUN;
        end
      end
      c_RUN: begin
        if (i_abort) begin
          w_next_state = c_IDLE;
        end else if (w_sample && (r_idx == c_LAST_IDX)) begin
          w_next_state = c_DONE;
        end
      end
      c_DONE: begin
        w_next_state = c_IDLE;
      end
      default: begin
        w_next_state = c_IDLE;
      end
    endcase
  end

  // Outputs decoded purely from registered state; dut_in parks at 0 off-sweep.
  always_comb begin
    o_busy   = (r_state == c_RUN);
    o_done   = (r_state == c_DONE);
    o_dut_in = (r_state == c_RUN) ? r_idx : 4'd0;
  end

  // Sweep datapath: settle countdown, capture, compare and result tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_expected   <= 16'd0;
      r_idx        <= 4'd0;
      r_cnt        <= 8'd0;
      r_tt         <= 16'd0;
      r_mm_cnt     <= 5'd0;
      r_first_fail <= 4'd0;
      r_match      <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (i_start) begin
            r_expected   <= i_expected_tt;
            r_idx        <= 4'd0;
            r_cnt        <= c_SETTLE;
            r_tt         <= 16'd0;
            r_mm_cnt     <= 5'd0;
            r_first_fail <= 4'd0;
            r_match      <= 1'b0;
          end
        end
        c_RUN: begin
          if (!i_abort) begin
            if (!w_sample) begin
              r_cnt <= r_cnt - 8'd1;
            end else begin
              r_tt[r_idx] <= i_dut_out;
              r_mm_cnt    <= w_mm_next;
              // Only the first miss of a sweep records its index.
              if (w_miss && (r_mm_cnt == 5'd0)) begin
                r_first_fail <= r_idx;
              end
              if (r_idx == c_LAST_IDX) begin
                r_match <= (w_mm_next == 5'd0);
              end else begin
                r_idx <= r_idx + 4'd1;
                r_cnt <= c_SETTLE;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_tt_captured    = r_tt;
  assign o_match          = r_match;
  assign o_mismatch_count = r_mm_cnt;
  assign o_first_fail_idx = r_first_fail;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_sweep_ctrl
// Brief    : Self-checking bench for tt_sweep_ctrl against a truth-table
//            level reference model, with directed and randomized sweeps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_sweep_ctrl;

  localparam int SETTLE = 2;
  localparam int HOLD   = SETTLE + 1;
  localparam int SWEEP  = 16 * HOLD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] exp_tt = 16'd0;
  logic [15:0] model_tt = 16'h601D;
  logic        dut_out;
  logic [3:0]  dut_in;
  logic        busy;
  logic        done;
  logic [15:0] tt_cap;
  logic        match;
  logic [4:0]  mm_cnt;
  logic [3:0]  ff_idx;

  int total = 0;
  int bad = 0;
  int done_pulses = 0;

  tt_sweep_ctrl #(.SETTLE_CYCLES(SETTLE)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (start),
    .i_abort          (abort),
    .i_expected_tt    (exp_tt),
    .i_dut_out        (dut_out),
    .o_dut_in         (dut_in),
    .o_busy           (busy),
    .o_done           (done),
    .o_tt_captured    (tt_cap),
    .o_match          (match),
    .o_mismatch_count (mm_cnt),
    .o_first_fail_idx (ff_idx)
  );

  always #5 clk = ~clk;

  // Behavioural gate netlist: a lookup into the model truth table.
  assign dut_out = model_tt[dut_in];

  always @(negedge clk) begin
    if (done) done_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int popc(input logic [15:0] v);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_dutin"}, dut_in, 0);
    chk({tag, "_tt"}, tt_cap, 0);
    chk({tag, "_match"}, match, 0);
    chk({tag, "_mm"}, mm_cnt, 0);
    chk({tag, "_ff"}, ff_idx, 0);
  endtask

  // Full sweep; with noise, expected_tt wiggles and start pulses arrive while busy.
  task automatic sweep(input logic [15:0] model, input logic [15:0] expv, input bit noise);
    int n;
    logic [15:0] diff;
    model_tt = model;
    exp_tt = expv;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_dutin", dut_in, 0);
    n = 0;
    while (!done && n < 200) begin
      if (noise) begin
        exp_tt = 16'($urandom);
        start = (n < SWEEP) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      tick;
      n++;
      if (n < SWEEP && n % 7 == 0) chk("vector", dut_in, n / HOLD);
    end
    start = 1'b0;
    diff = model ^ expv;
    chk("done_latency", n, SWEEP);
    chk("done_busy", busy, 0);
    chk("tt", tt_cap, model);
    chk("match", match, (diff == 16'd0));
    chk("mm_cnt", mm_cnt, popc(diff));
    chk("ff_idx", ff_idx, lowest(diff));
    tick;
    chk("done_pulse_end", done, 0);
    chk("hold_busy", busy, 0);
    chk("hold_tt", tt_cap, model);
  endtask

  // Abort after abort_at cycles; vectors fully sampled before it are kept.
  task automatic abort_sweep(input logic [15:0] model, input logic [15:0] expv, input int abort_at);
    int pulses;
    int sampled;
    logic [15:0] mask;
    logic [15:0] diff;
    pulses = done_pulses;
    model_tt = model;
    exp_tt = expv;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 1; i < abort_at; i++) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    sampled = (abort_at - 1) / HOLD;
    mask = 16'((32'd1 << sampled) - 1);
    diff = (model ^ expv) & mask;
    chk("abort_busy", busy, 0);
    chk("abort_dutin", dut_in, 0);
    chk("abort_tt", tt_cap, model & mask);
    chk("abort_mm", mm_cnt, popc(diff));
    chk("abort_ff", ff_idx, lowest(diff));
    chk("abort_match", match, 0);
    for (int i = 0; i < SWEEP; i++) tick;
    chk("abort_no_done", done_pulses, pulses);
    chk("abort_hold_tt", tt_cap, model & mask);
  endtask

  initial begin
    #3;
    chk_zero("reset");
    tick;
    tick;
    rst = 1'b0;
    tick;
    chk_zero("post_reset");

    sweep(16'h601D, 16'h601D, 1'b0);
    sweep(16'h601D, 16'h601C, 1'b0);
    sweep(16'h601D, 16'h9FE2, 1'b0);
    sweep(16'h601D, 16'h611D, 1'b0);

    // Abort during vector 5 settle (edge 16 after acceptance).
    abort_sweep(16'h601D, 16'h601D, 16);
    sweep(16'h601D, 16'h601D, 1'b0);

    // Asynchronous reset during vector 9.
    model_tt = 16'h601D;
    exp_tt = 16'h0000;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 1; i < 28; i++) tick;
    chk("pre_rst_vector", dut_in, 9);
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    #2;
    rst = 1'b0;
    tick;
    chk_zero("after_mid_rst");

    // Start pulses and expected_tt changes while busy must not disturb timing.
    sweep(16'h601D, 16'h611D, 1'b1);

    for (int k = 0; k < 8; k++) begin
      logic [15:0] m;
      logic [15:0] e;
      m = 16'($urandom);
      e = ($urandom_range(0, 3) == 0) ? m : (m ^ 16'($urandom));
      sweep(m, e, 1'b1);
    end

    for (int k = 0; k < 4; k++) begin
      abort_sweep(16'($urandom), 16'($urandom), int'($urandom_range(1, SWEEP - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Sequencing controller that exhaustively drives a 4-input, 1-output combinational gate netlist (e.g. an ABC-synthesized NOR/NOT circuit for a hex truth table such as 0x601D) through all 16 input vectors. It waits a programmable settle time per vector, captures the output into a 16-bit truth-table word, and compares it against an expected hex truth table. It sits between the design-evaluation harness and the gate netlist, which remains purely combinational.

## Interface

- SETTLE_CYCLES, default 2: extra cycles each vector is held before sampling; legal range 0..255.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; accepted only in IDLE.
- abort  input  1  synchronous cancel of a running sweep.
- expected_tt  input  16  expected truth table; latched when start is accepted.
- dut_out  input  1  netlist output.
- dut_in  output  4  netlist inputs; dut_in[0] drives input _0 (minterm LSB).
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse when a sweep completes normally.
- tt_captured  output  16  bit i = dut_out sampled for vector i.
- match  output  1  tt_captured equals latched expected_tt; valid from done.
- mismatch_count  output  5  number of differing bits, 0..16.
- first_fail_idx  output  4  lowest mismatching vector index; 0 when mismatch_count = 0.

## Operation

- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN. Same edge: latch expected_tt; clear tt_captured, mismatch_count, first_fail_idx and match; set vector index to 0 and settle counter to SETTLE_CYCLES.
  - RUN: dut_in = vector index.
    - Settle counter > 0: decrement.
    - Settle counter = 0: sample dut_out into tt_captured[index]; compare against latched expected bit.
    - On mismatch: increment mismatch_count. If this is the first mismatch, load first_fail_idx with the index.
    - Index < 15: increment index; reload counter.
    - Index = 15 -> DONE.
  - DONE: lasts one cycle; done=1; match = (mismatch_count = 0). Then -> IDLE.
- abort=1 in RUN -> IDLE on that edge. Effects:
  - No done pulse; match stays 0.
  - tt_captured, mismatch_count and first_fail_idx keep partial values.
  - dut_in returns to 0.
  - abort has priority over sampling on the same edge.
- start while busy: ignored. start in DONE: ignored (accepted in the following IDLE cycle).
- abort in IDLE or DONE: ignored.
- Changes to expected_tt during a sweep have no effect.
- Results hold stable in IDLE until the next accepted start.
- mismatch_count saturates naturally at 16; no wrap is possible.

## Timing

- Reset values, asserted asynchronously: state IDLE, dut_in=0, busy=0, done=0, tt_captured=0, match=0, mismatch_count=0, first_fail_idx=0.
- Reset mid-sweep discards everything and applies the values above.
- Start accepted at edge E0:
  - busy=1 and dut_in=0 from E0.
  - Each vector is held SETTLE_CYCLES+1 cycles and sampled on the final edge of its hold.
  - Vector 15 is sampled at edge E0+16*(SETTLE_CYCLES+1). At that edge the state enters DONE, busy=0, done=1 and all results are valid.
  - At the next edge done returns to 0.
- dut_in changes only on sample edges, which is glitch-free per vector. dut_out is treated as valid after the settle period.
- All outputs are registered; no combinational path from dut_out or start to any output.

## Test plan

- Netlist model = 0x601D, expected_tt=0x601D, SETTLE_CYCLES=2, start pulse:
  - done exactly 48 cycles after the accepting edge;
  - tt_captured=0x601D, match=1, mismatch_count=0, first_fail_idx=0.
- Same model, expected_tt=0x601C: tt_captured=0x601D, match=0, mismatch_count=1, first_fail_idx=0.
- Same model, expected_tt=0x9FE2 (the bitwise complement): mismatch_count=16, first_fail_idx=0, match=0.
- Netlist model = 0x601D, expected_tt=0x611D: mismatch_count=1, first_fail_idx=8.
- Start a sweep, assert abort during vector 5 settle:
  - busy=0 on the next edge; no done pulse;
  - tt_captured bits 0..4 = 0x1D, bits 5..15 = 0;
  - a new start then completes normally.
- Assert rst mid-sweep (vector 9): all outputs go to 0 immediately. start pulses during busy are ignored, and the done timing stays 48 cycles from the original accepting edge.
